ps2_frame_receiver: RTL and testbench
=====================================

// Module: ps2_frame_receiver
// PURPOSE
//  Parametrised PS/2 device-to-host receiver: synchronises raw ps2_clk/ps2_data,
//  deframes 11-bit frames (start, DATA_BITS data LSB-first, odd parity, stop),
//  checks framing/parity, recovers from stalled frames by timeout, and buffers
//  good bytes in a FIFO. Sits between the keyboard pins and the scan-code decoder.
// PARAMETERS
//  DATA_BITS      8     payload bits per frame
//  FIFO_DEPTH     4     received-byte buffer entries (power of 2, >=2)
//  SYNC_STAGES    2     flops in each input synchroniser (>=2)
//  TIMEOUT_CYCLES 2080  clk cycles without a ps2_clk falling edge that abort a frame (1 ms @ 2.08 MHz)
// PORTS
//  clk        in   1          system clock (internal oscillator, 2.08 MHz)
//  reset      in   1          asynchronous, active-high reset
//  ps2_clk    in   1          raw PS/2 clock pin (async)
//  ps2_data   in   1          raw PS/2 data pin (async)
//  rd_en      in   1          pop head of FIFO; ignored when rd_valid=0
//  clr_err    in   1          clears sticky overflow and err_code
//  rd_data    out  DATA_BITS  FIFO head (first-word-fall-through); 0 when empty
//  rd_valid   out  1          FIFO not empty
//  frame_err  out  1          one-cycle pulse on any rejected frame
//  err_code   out  2          last error: 00 none, 01 parity, 10 stop/start, 11 timeout
//  overflow   out  1          sticky: a good frame was dropped because FIFO full
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, FIFO empty, synchronisers 1 (bus idle-high).
//  - Edge detect: fall = sync_clk_q & ~sync_clk; ps2_data sampled (synced) on fall.
//  - FSM (advances only on fall):
//    IDLE  : data=0 -> DATA, bit_cnt=0; data=1 -> stay IDLE, err 10, frame_err pulse.
//    DATA  : shift into shreg LSB-first; after DATA_BITS-th bit -> PARITY.
//    PARITY: capture p; -> STOP.
//    STOP  : stop=1 and ^{shreg,p}=1 -> push; parity bad -> err 01; stop=0 -> err 10
//            (parity has priority). Always -> IDLE.
//  - Timeout: counter clears on every fall and in IDLE; reaching TIMEOUT_CYCLES in
//    DATA/PARITY/STOP -> IDLE, err 11, frame_err pulse, partial byte discarded.
//  - Latency: byte visible (rd_valid=1) on the clk cycle after the stop-bit fall is
//    detected; pin-to-fall detection is SYNC_STAGES+1 cycles.
//  - FIFO: push only on good frame. Full and no rd_en -> byte dropped, overflow=1.
//    Full with rd_en same cycle -> pop and push both happen, no overflow.
//    Empty with rd_en -> no change. Pointers wrap modulo FIFO_DEPTH; count width
//    $clog2(FIFO_DEPTH)+1.
//  - err_code holds until clr_err or a newer error; clr_err and new error same
//    cycle -> new error wins. overflow same rule.
//  - Reset mid-frame: frame discarded, FIFO cleared; receiver resynchronises on next
//    start bit (frame already in progress yields err 10 or 11, never bad data).
// STRUCTURE
//  - ps2_pkg: typedef enum {IDLE, DATA, PARITY, STOP} ps2_state_t;
//    typedef enum logic [1:0] {ERR_NONE, ERR_PARITY, ERR_FRAME, ERR_TIMEOUT} ps2_err_t.
//  - Sub-module ps2_byte_fifo (DATA_BITS, FIFO_DEPTH): push/pop/full/empty/fwt head.
//  - Top holds synchronisers, edge detect, FSM, shift reg, timeout counter, error regs.
// TESTING (PS/2 clock modelled at 12.5 kHz, 2.08 MHz clk)
//  1 Frame 0x1C, parity 0, stop 1 -> rd_valid=1, rd_data=8'h1C, err_code=00.
//  2 Frame 0x1C with parity 1 -> frame_err one pulse, err_code=01, rd_valid stays 0.
//  3 Frame 0xF0 with stop 0 -> err_code=10, FIFO empty; next good 0x1C accepted.
//  4 Stop ps2_clk after 4 data bits for >2080 cycles -> err_code=11; following
//    0x32 frame received correctly.
//  5 Five good frames 0x01..0x05, no reads -> overflow=1, reads return 01,02,03,04
//    then rd_valid=0; rd_en held on 6th frame while full -> no overflow, 06 queued.
//  6 Assert reset mid-frame (after 5 data bits) -> all outputs 0; next 0x5A frame
//    received; clr_err clears err_code/overflow to 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 device-to-host receiver.
// Frame state and error codes used by the deframer and its consumers.
`timescale 1ns/1ps
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_PARITY,
      ERR_FRAME,
      ERR_TIMEOUT
   } ps2_err_t;

endpackage

// File: rtl/ps2_byte_fifo.sv
// Small first-word-fall-through byte buffer for received PS/2 frames.
// A pop frees room for a push in the same cycle.
`timescale 1ns/1ps
module ps2_byte_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [DATA_BITS-1:0] push_data,
   input  logic                 pop,
   output logic [DATA_BITS-1:0] head,
   output logic                 full,
   output logic                 empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        cnt;
   logic                 do_push;
   logic                 do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(FIFO_DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host receiver: pin synchronisers, frame deframer,
// parity/stop checks, stall timeout and a byte FIFO toward the decoder.
`timescale 1ns/1ps
module ps2_frame_receiver
   import ps2_pkg::*;
#(
   parameter int DATA_BITS      = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 2080
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ps2_clk,
   input  logic                 ps2_data,
   input  logic                 rd_en,
   input  logic                 clr_err,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 frame_err,
   output logic [1:0]           err_code,
   output logic                 overflow
);

   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   sync_clk;
   logic                   sync_clk_q;
   logic                   sync_dat;
   logic                   fall;

   ps2_state_t           state, state_n;
   logic [BW-1:0]        bit_cnt, bit_cnt_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic                 par, par_n;
   logic [TW-1:0]        tmo_cnt, tmo_cnt_n;
   ps2_err_t             err_q, err_n;
   logic                 ovf_q, ovf_n;
   logic                 fe_q;
   logic                 err_set;
   ps2_err_t             err_val;
   logic                 push;
   logic                 fifo_full;
   logic                 fifo_empty;

   // Idle-high bus: synchronisers reset to 1 so reset never fakes a fall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync   <= '1;
         dat_sync   <= '1;
         sync_clk_q <= 1'b1;
      end else begin
         clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync   <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
         sync_clk_q <= sync_clk;
      end
   end

   assign sync_clk = clk_sync[SYNC_STAGES-1];
   assign sync_dat = dat_sync[SYNC_STAGES-1];
   assign fall     = sync_clk_q & ~sync_clk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par     <= 1'b0;
         tmo_cnt <= '0;
         err_q   <= ERR_NONE;
         ovf_q   <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         shreg   <= shreg_n;
         par     <= par_n;
         tmo_cnt <= tmo_cnt_n;
         err_q   <= err_n;
         ovf_q   <= ovf_n;
         fe_q    <= err_set;
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_n     = par;
      err_set   = 1'b0;
      err_val   = ERR_NONE;
      push      = 1'b0;
      tmo_cnt_n = (state == IDLE || fall) ? '0 : tmo_cnt + 1'b1;

      unique case (state)
         IDLE: begin
            if (fall) begin
               if (!sync_dat) begin
                  state_n   = DATA;
                  bit_cnt_n = '0;
               end else begin
                  err_set = 1'b1;
                  err_val = ERR_FRAME;
               end
            end
         end
         DATA: begin
            if (fall) begin
               shreg_n   = {sync_dat, shreg[DATA_BITS-1:1]};
               bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == BW'(DATA_BITS - 1))
                  state_n = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
               par_n   = sync_dat;
               state_n = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               state_n = IDLE;
               if (!(^{shreg, par})) begin
                  err_set = 1'b1;
                  err_val = ERR_PARITY;
               end else if (!sync_dat) begin
                  err_set = 1'b1;
                  err_val = ERR_FRAME;
               end else begin
                  push = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // A stalled frame is abandoned; the partial byte never reaches the FIFO.
      if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
         state_n = IDLE;
         err_set = 1'b1;
         err_val = ERR_TIMEOUT;
      end

      err_n = err_q;
      if (err_set)
         err_n = err_val;
      else if (clr_err)
         err_n = ERR_NONE;

      ovf_n = ovf_q;
      if (push && fifo_full && !rd_en)
         ovf_n = 1'b1;
      else if (clr_err)
         ovf_n = 1'b0;
   end

   ps2_byte_fifo #(
      .DATA_BITS  (DATA_BITS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (shreg),
      .pop       (rd_en),
      .head      (rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign rd_valid  = ~fifo_empty;
   assign frame_err = fe_q;
   assign err_code  = err_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver with a byte scoreboard.
`timescale 1ns/1ps
module tb_ps2_frame_receiver;

   localparam int HALF = 83;
   localparam int QTR  = 41;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       frame_err;
   logic [1:0] err_code;
   logic       overflow;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];
   int         fe_pulse = 0;
   int         fe_hi = 0;
   logic       fe_prev = 1'b0;
   int         fe0;

   ps2_frame_receiver dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rd_en     (rd_en),
      .clr_err   (clr_err),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .frame_err (frame_err),
      .err_code  (err_code),
      .overflow  (overflow)
   );

   always #240 clk = ~clk;

   always @(posedge clk) begin
      if (frame_err)
         fe_hi <= fe_hi + 1;
      if (frame_err && !fe_prev)
         fe_pulse <= fe_pulse + 1;
      fe_prev <= frame_err;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b,
                                            input bit bad_par,
                                            input bit bad_stop);
      logic p;
      p = ~(^b) ^ bad_par;
      return {~bad_stop, p, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int nbits,
                            input bit rd_at_stop);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         cycles(QTR);
         ps2_clk = 1'b0;
         if (rd_at_stop && i == 10) begin
            @(posedge clk);
            @(posedge clk);
            #1;
            chk("head_at_push", rd_data, exp_q.pop_front());
            rd_en = 1'b1;
            @(posedge clk);
            #1;
            rd_en = 1'b0;
            cycles(HALF - 3);
         end else begin
            cycles(HALF);
         end
         ps2_clk = 1'b1;
         cycles(HALF - QTR);
      end
   endtask

   task automatic send(input logic [7:0] b, input bit bad_par,
                       input bit bad_stop);
      send_bits(mk_frame(b, bad_par, bad_stop), 11, 1'b0);
      cycles(2);
   endtask

   task automatic read_one(input string tag);
      int w;
      w = 0;
      while (!rd_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_valid"}, rd_valid, 1);
      if (rd_valid) begin
         chk(tag, rd_data, exp_q.pop_front());
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
      end
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rd_en    = 1'b0;
      clr_err  = 1'b0;
      cycles(5);
      chk("rst_valid", rd_valid, 0);
      chk("rst_data", rd_data, 0);
      chk("rst_fe", frame_err, 0);
      chk("rst_err", err_code, 0);
      chk("rst_ovf", overflow, 0);
      reset = 1'b0;
      cycles(5);

      exp_q.push_back(8'h1C);
      send(8'h1C, 0, 0);
      chk("t1_err", err_code, 0);
      read_one("t1_data");
      cycles(2);
      chk("t1_empty", rd_valid, 0);

      fe0 = fe_pulse;
      send(8'h1C, 1, 0);
      chk("t2_err", err_code, 1);
      chk("t2_fe", fe_pulse - fe0, 1);
      chk("t2_empty", rd_valid, 0);

      fe0 = fe_pulse;
      send(8'hF0, 0, 1);
      chk("t3_err", err_code, 2);
      chk("t3_fe", fe_pulse - fe0, 1);
      chk("t3_empty", rd_valid, 0);
      exp_q.push_back(8'h1C);
      send(8'h1C, 0, 0);
      read_one("t3_data");
      chk("t3_err_hold", err_code, 2);

      fe0 = fe_pulse;
      send_bits(mk_frame(8'hAA, 0, 0), 5, 1'b0);
      cycles(2200);
      chk("t4_err", err_code, 3);
      chk("t4_fe", fe_pulse - fe0, 1);
      chk("t4_empty", rd_valid, 0);
      exp_q.push_back(8'h32);
      send(8'h32, 0, 0);
      read_one("t4_data");

      for (int b = 1; b <= 5; b++) begin
         if (b <= 4)
            exp_q.push_back(8'(b));
         send(8'(b), 0, 0);
      end
      chk("t5_ovf", overflow, 1);
      chk("t5_head", rd_data, 8'h01);
      pulse_clr();
      chk("t5_clr_ovf", overflow, 0);
      chk("t5_clr_err", err_code, 0);
      exp_q.push_back(8'h06);
      send_bits(mk_frame(8'h06, 0, 0), 11, 1'b1);
      cycles(2);
      chk("t5_no_ovf", overflow, 0);
      for (int k = 0; k < 4; k++)
         read_one("t5_data");
      cycles(2);
      chk("t5_empty", rd_valid, 0);
      chk("t5_empty_data", rd_data, 0);

      send(8'h55, 1, 0);
      exp_q.push_back(8'h77);
      send(8'h77, 0, 0);
      chk("t6_pre_valid", rd_valid, 1);
      chk("t6_pre_err", err_code, 1);
      send_bits(mk_frame(8'hC3, 0, 0), 6, 1'b0);
      reset = 1'b1;
      cycles(2);
      chk("t6_rst_valid", rd_valid, 0);
      chk("t6_rst_data", rd_data, 0);
      chk("t6_rst_err", err_code, 0);
      chk("t6_rst_ovf", overflow, 0);
      chk("t6_rst_fe", frame_err, 0);
      exp_q.delete();
      reset = 1'b0;
      cycles(300);
      chk("t6_quiet_err", err_code, 0);
      chk("t6_quiet_valid", rd_valid, 0);
      exp_q.push_back(8'h5A);
      send(8'h5A, 0, 0);
      read_one("t6_data");
      send(8'h5A, 1, 0);
      chk("t6_err", err_code, 1);
      pulse_clr();
      chk("t6_clr_err", err_code, 0);
      chk("fe_one_cycle", fe_hi, fe_pulse);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
